// File: rtl/track_collision_resolver.sv
// Track collision resolver: walks the segment table once per physics tick,
// drives the latched car state to the checker bank, and folds the per-segment
// results into one resolved velocity plus collision/off-track/error flags.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_start                         begin a scan (only honoured in IDLE)
//   i_x, i_y, i_v_x, i_v_y          car state, latched on accepted start
//   o_x, o_y, o_chk_v_x, o_chk_v_y  latched car state to the checker bank
//   o_seg_req, o_seg_idx            one-cycle fetch pulse and segment index
//   i_seg_valid, i_seg_type         checker result strobe and segment type
//   i_seg_in_region, i_seg_collision, i_seg_v_x, i_seg_v_y
//                                   checker result fields
//   o_busy, o_done                  scan in progress, one-cycle completion
//   o_v_x, o_v_y                    resolved velocity, held until next done
//   o_collision, o_off_track, o_error
//                                   scan status, held until next done
module track_collision_resolver #(
   parameter int H_WIDTH      = 12,
   parameter int V_WIDTH      = 12,
   parameter int VEL_WIDTH    = 16,
   parameter int NUM_SEGMENTS = 16,
   parameter int TIMEOUT      = 15,
   localparam int IDXW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [H_WIDTH-1:0]   i_x,
   input  logic [V_WIDTH-1:0]   i_y,
   input  logic [VEL_WIDTH-1:0] i_v_x,
   input  logic [VEL_WIDTH-1:0] i_v_y,
   output logic [H_WIDTH-1:0]   o_x,
   output logic [V_WIDTH-1:0]   o_y,
   output logic [VEL_WIDTH-1:0] o_chk_v_x,
   output logic [VEL_WIDTH-1:0] o_chk_v_y,
   output logic                 o_seg_req,
   output logic [IDXW-1:0]      o_seg_idx,
   input  logic                 i_seg_valid,
   input  logic [1:0]           i_seg_type,
   input  logic                 i_seg_in_region,
   input  logic                 i_seg_collision,
   input  logic [VEL_WIDTH-1:0] i_seg_v_x,
   input  logic [VEL_WIDTH-1:0] i_seg_v_y,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [VEL_WIDTH-1:0] o_v_x,
   output logic [VEL_WIDTH-1:0] o_v_y,
   output logic                 o_collision,
   output logic                 o_off_track,
   output logic                 o_error
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_SEGMENTS - 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] SEG_H   = 2'd0;
   localparam logic [1:0] SEG_V   = 2'd1;
   localparam logic [1:0] SEG_C   = 2'd2;
   localparam logic [1:0] SEG_END = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [IDXW-1:0]      idx_q,   idx_d;
   logic [TW-1:0]        tmo_q,   tmo_d;

   // latched car state, seen by the checkers for the whole scan
   logic [H_WIDTH-1:0]   x_q,     x_d;
   logic [V_WIDTH-1:0]   y_q,     y_d;
   logic [VEL_WIDTH-1:0] lvx_q,   lvx_d;
   logic [VEL_WIDTH-1:0] lvy_q,   lvy_d;

   // working velocity and accumulated scan status
   logic [VEL_WIDTH-1:0] wvx_q,   wvx_d;
   logic [VEL_WIDTH-1:0] wvy_q,   wvy_d;
   logic                 hit_q,   hit_d;
   logic                 rgn_q,   rgn_d;

   // held results
   logic [VEL_WIDTH-1:0] ovx_q,   ovx_d;
   logic [VEL_WIDTH-1:0] ovy_q,   ovy_d;
   logic                 col_q,   col_d;
   logic                 off_q,   off_d;
   logic                 err_q,   err_d;

   logic                 fin;
   logic                 tmo_fire;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         tmo_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         lvx_q   <= '0;
         lvy_q   <= '0;
         wvx_q   <= '0;
         wvy_q   <= '0;
         hit_q   <= 1'b0;
         rgn_q   <= 1'b0;
         ovx_q   <= '0;
         ovy_q   <= '0;
         col_q   <= 1'b0;
         off_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         x_q     <= x_d;
         y_q     <= y_d;
         lvx_q   <= lvx_d;
         lvy_q   <= lvy_d;
         wvx_q   <= wvx_d;
         wvy_q   <= wvy_d;
         hit_q   <= hit_d;
         rgn_q   <= rgn_d;
         ovx_q   <= ovx_d;
         ovy_q   <= ovy_d;
         col_q   <= col_d;
         off_q   <= off_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      x_d      = x_q;
      y_d      = y_q;
      lvx_d    = lvx_q;
      lvy_d    = lvy_q;
      wvx_d    = wvx_q;
      wvy_d    = wvy_q;
      hit_d    = hit_q;
      rgn_d    = rgn_q;
      ovx_d    = ovx_q;
      ovy_d    = ovy_q;
      col_d    = col_q;
      off_d    = off_q;
      err_d    = err_q;
      fin      = 1'b0;
      tmo_fire = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               x_d     = i_x;
               y_d     = i_y;
               lvx_d   = i_v_x;
               lvy_d   = i_v_y;
               wvx_d   = i_v_x;
               wvy_d   = i_v_y;
               hit_d   = 1'b0;
               rgn_d   = 1'b0;
               idx_d   = '0;
               tmo_d   = '0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (i_seg_valid) begin
               if (i_seg_type == SEG_END) begin
                  fin = 1'b1;
               end else begin
                  rgn_d = rgn_q | i_seg_in_region;
                  // a collision outside the region is not trusted
                  if (i_seg_collision && i_seg_in_region) begin
                     hit_d = 1'b1;
                     case (i_seg_type)
                        SEG_H: wvy_d = '0;
                        SEG_V: wvx_d = '0;
                        SEG_C: begin
                           wvx_d = i_seg_v_x;
                           wvy_d = i_seg_v_y;
                        end
                        default: ;
                     endcase
                  end
                  if (idx_q == IDX_LAST) begin
                     fin = 1'b1;
                  end else begin
                     idx_d   = idx_q + IDXW'(1);
                     state_d = S_FETCH;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_fire = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // results load on entry to DONE so they are valid with o_done
      if (fin) begin
         state_d = S_DONE;
         off_d   = !rgn_d;
         col_d   = hit_d;
         err_d   = 1'b0;
         ovx_d   = rgn_d ? wvx_d : '0;
         ovy_d   = rgn_d ? wvy_d : '0;
      end

      // aborted scan: report the untouched input velocity
      if (tmo_fire) begin
         state_d = S_DONE;
         off_d   = 1'b0;
         col_d   = 1'b0;
         err_d   = 1'b1;
         ovx_d   = lvx_q;
         ovy_d   = lvy_q;
      end
   end

   assign o_x         = x_q;
   assign o_y         = y_q;
   assign o_chk_v_x   = lvx_q;
   assign o_chk_v_y   = lvy_q;
   assign o_seg_req   = (state_q == S_FETCH);
   assign o_seg_idx   = idx_q;
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = (state_q == S_DONE);
   assign o_v_x       = ovx_q;
   assign o_v_y       = ovy_q;
   assign o_collision = col_q;
   assign o_off_track = off_q;
   assign o_error     = err_q;

endmodule

// File: tb/tb_track_collision_resolver.sv
// Bench for track_collision_resolver: directed segment tables, a table-level
// model of the scan result and timing, and a per-cycle output compare.
module tb_track_collision_resolver;

   localparam int NS  = 16;
   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [11:0] i_x = '0, i_y = '0;
   logic [15:0] i_v_x = '0, i_v_y = '0;
   logic [11:0] o_x, o_y;
   logic [15:0] o_chk_v_x, o_chk_v_y;
   logic        o_seg_req;
   logic [3:0]  o_seg_idx;
   logic        seg_valid = 1'b0;
   logic [1:0]  seg_type = '0;
   logic        seg_rgn = 1'b0, seg_col = 1'b0;
   logic [15:0] seg_vx = '0, seg_vy = '0;
   logic        o_busy, o_done;
   logic [15:0] o_v_x, o_v_y;
   logic        o_collision, o_off_track, o_error;

   track_collision_resolver dut (
      .i_clk(clk), .i_rst(rst), .i_start(i_start),
      .i_x(i_x), .i_y(i_y), .i_v_x(i_v_x), .i_v_y(i_v_y),
      .o_x(o_x), .o_y(o_y),
      .o_chk_v_x(o_chk_v_x), .o_chk_v_y(o_chk_v_y),
      .o_seg_req(o_seg_req), .o_seg_idx(o_seg_idx),
      .i_seg_valid(seg_valid), .i_seg_type(seg_type),
      .i_seg_in_region(seg_rgn), .i_seg_collision(seg_col),
      .i_seg_v_x(seg_vx), .i_seg_v_y(seg_vy),
      .o_busy(o_busy), .o_done(o_done),
      .o_v_x(o_v_x), .o_v_y(o_v_y),
      .o_collision(o_collision), .o_off_track(o_off_track),
      .o_error(o_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // segment table
   logic [1:0]  s_type [NS];
   bit          s_reg  [NS];
   bit          s_col  [NS];
   bit          s_nv   [NS];
   logic [15:0] s_tx   [NS];
   logic [15:0] s_ty   [NS];

   // model state
   logic [11:0] lat_x = '0, lat_y = '0;
   logic [15:0] lat_vx = '0, lat_vy = '0;
   int          m_lat;
   logic [15:0] m_vx, m_vy;
   bit          m_col, m_off, m_err;
   logic [15:0] h_vx = '0, h_vy = '0;
   bit          h_col = 0, h_off = 0, h_err = 0;
   int          t0 = 0, exp_done = -1, busy_from = 0;
   bit          chk_en = 0, done_seen = 0;
   int          cap_cyc;
   logic [15:0] cap_vx, cap_vy;
   logic        cap_col, cap_off, cap_err;
   logic [3:0]  cap_idx;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
      end
   endtask

   task automatic clear_segs();
      for (int i = 0; i < NS; i++) begin
         s_type[i] = 2'd0; s_reg[i] = 0; s_col[i] = 0;
         s_nv[i] = 0; s_tx[i] = '0; s_ty[i] = '0;
      end
   endtask

   task automatic seg(input int i, input logic [1:0] t, input bit r,
                      input bit c, input logic [15:0] tx,
                      input logic [15:0] ty);
      s_type[i] = t; s_reg[i] = r; s_col[i] = c;
      s_tx[i] = tx; s_ty[i] = ty;
   endtask

   // scan result from the table rules; segment i is fetched in
   // cycle 2i+1 after start and answered one cycle later
   task automatic model();
      logic [15:0] wx, wy;
      bit rg, ht;
      wx = lat_vx; wy = lat_vy; rg = 0; ht = 0;
      m_err = 0; m_lat = 2 * NS + 1;
      for (int i = 0; i < NS; i++) begin
         if (s_nv[i]) begin
            m_lat = 2 * i + 2 + TMO;
            m_err = 1; m_col = 0; m_off = 0;
            m_vx = lat_vx; m_vy = lat_vy;
            return;
         end
         if (s_type[i] == 2'd3) begin
            m_lat = 2 * i + 3;
            break;
         end
         rg = rg | s_reg[i];
         if (s_reg[i] && s_col[i]) begin
            ht = 1;
            if (s_type[i] == 2'd0) wy = '0;
            else if (s_type[i] == 2'd1) wx = '0;
            else begin wx = s_tx[i]; wy = s_ty[i]; end
         end
      end
      m_off = !rg; m_col = ht;
      m_vx = rg ? wx : 16'h0;
      m_vy = rg ? wy : 16'h0;
   endtask

   // checker bank stand-in: answers one cycle after each request
   initial begin
      int k;
      forever begin
         @(negedge clk);
         if (o_seg_req === 1'b1) begin
            k = int'(o_seg_idx);
            @(posedge clk); #1;
            if (!s_nv[k]) begin
               seg_valid = 1'b1; seg_type = s_type[k];
               seg_rgn = s_reg[k]; seg_col = s_col[k];
               seg_vx = s_tx[k]; seg_vy = s_ty[k];
            end
            @(posedge clk); #1;
            seg_valid = 1'b0;
         end
      end
   end

   // per-cycle compare
   always @(negedge clk) begin
      if (chk_en) begin
         bit ed, eb;
         ed = (cyc == exp_done);
         eb = (cyc >= busy_from) && (cyc <= exp_done);
         chk("done", {31'd0, o_done}, {31'd0, ed});
         chk("busy", {31'd0, o_busy}, {31'd0, eb});
         if (ed) begin
            h_vx = m_vx; h_vy = m_vy;
            h_col = m_col; h_off = m_off; h_err = m_err;
         end
         if (o_done === 1'b1) begin
            done_seen = 1;
            cap_cyc = cyc; cap_vx = o_v_x; cap_vy = o_v_y;
            cap_col = o_collision; cap_off = o_off_track;
            cap_err = o_error; cap_idx = o_seg_idx;
         end
         chk("v_x", {16'd0, o_v_x}, {16'd0, h_vx});
         chk("v_y", {16'd0, o_v_y}, {16'd0, h_vy});
         chk("collision", {31'd0, o_collision}, {31'd0, h_col});
         chk("off_track", {31'd0, o_off_track}, {31'd0, h_off});
         chk("error", {31'd0, o_error}, {31'd0, h_err});
         if (eb) begin
            chk("chk_v_x", {16'd0, o_chk_v_x}, {16'd0, lat_vx});
            chk("chk_v_y", {16'd0, o_chk_v_y}, {16'd0, lat_vy});
            chk("pos_x", {20'd0, o_x}, {20'd0, lat_x});
            chk("pos_y", {20'd0, o_y}, {20'd0, lat_y});
         end
      end
   end

   task automatic arm(input logic [11:0] x, input logic [11:0] y,
                      input logic [15:0] vx, input logic [15:0] vy);
      lat_x = x; lat_y = y; lat_vx = vx; lat_vy = vy;
      i_x = x; i_y = y; i_v_x = vx; i_v_y = vy;
      model();
      t0 = cyc;
      exp_done = t0 + m_lat;
      busy_from = t0 + 1;
      done_seen = 0;
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 80 && !done_seen; i++) @(negedge clk);
      chk({nm, "_done_seen"}, {31'd0, done_seen}, 32'd1);
      repeat (2) @(posedge clk);
   endtask

   task automatic run(input string nm, input logic [15:0] vx,
                      input logic [15:0] vy);
      @(posedge clk); #1;
      arm(12'd100, 12'd50, vx, vy);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_done(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      clear_segs();
      @(posedge clk); #1;
      chk_en = 1;
      @(posedge clk); #1;
      chk("rst_idx", {28'd0, o_seg_idx}, 32'd0);
      chk("rst_req", {31'd0, o_seg_req}, 32'd0);
      rst = 1'b0;

      // T1: no collision
      clear_segs();
      seg(0, 2'd0, 1, 0, 16'h0, 16'h0);
      seg(1, 2'd3, 0, 0, 16'h0, 16'h0);
      run("t1", 16'h0180, 16'h0080);
      chk("t1_lat", cap_cyc - t0, 32'd5);
      chk("t1_vx", {16'd0, cap_vx}, 32'h0180);
      chk("t1_vy", {16'd0, cap_vy}, 32'h0080);
      chk("t1_col", {31'd0, cap_col}, 32'd0);
      chk("t1_off", {31'd0, cap_off}, 32'd0);

      // T2: horiz then vert collision
      clear_segs();
      seg(0, 2'd0, 1, 1, 16'h0, 16'h0);
      seg(1, 2'd1, 1, 1, 16'h0, 16'h0);
      seg(2, 2'd3, 0, 0, 16'h0, 16'h0);
      run("t2", 16'h0180, 16'h0080);
      chk("t2_lat", cap_cyc - t0, 32'd7);
      chk("t2_vx", {16'd0, cap_vx}, 32'h0);
      chk("t2_vy", {16'd0, cap_vy}, 32'h0);
      chk("t2_col", {31'd0, cap_col}, 32'd1);

      // T3: circle then horiz, scan order matters
      clear_segs();
      seg(0, 2'd2, 1, 1, 16'h0100, 16'hFF00);
      seg(1, 2'd0, 1, 1, 16'h0, 16'h0);
      seg(2, 2'd3, 0, 0, 16'h0, 16'h0);
      run("t3", 16'h0180, 16'h0080);
      chk("t3_vx", {16'd0, cap_vx}, 32'h0100);
      chk("t3_vy", {16'd0, cap_vy}, 32'h0000);

      // T4: off track, full table, collision outside region ignored
      clear_segs();
      seg(5, 2'd1, 0, 1, 16'h0, 16'h0);
      run("t4", 16'h0180, 16'h0080);
      chk("t4_lat", cap_cyc - t0, 32'd33);
      chk("t4_off", {31'd0, cap_off}, 32'd1);
      chk("t4_col", {31'd0, cap_col}, 32'd0);
      chk("t4_vx", {16'd0, cap_vx}, 32'h0);
      chk("t4_idx", {28'd0, cap_idx}, 32'd15);

      // T5: seg1 never answers
      clear_segs();
      seg(0, 2'd0, 1, 1, 16'h0, 16'h0);
      s_nv[1] = 1;
      run("t5", 16'h0180, 16'h0080);
      chk("t5_lat", cap_cyc - t0, 32'd19);
      chk("t5_err", {31'd0, cap_err}, 32'd1);
      chk("t5_vx", {16'd0, cap_vx}, 32'h0180);
      chk("t5_vy", {16'd0, cap_vy}, 32'h0080);
      chk("t5_col", {31'd0, cap_col}, 32'd0);

      // T6: normal scan after abort
      clear_segs();
      seg(0, 2'd1, 1, 1, 16'h0, 16'h0);
      seg(1, 2'd3, 0, 0, 16'h0, 16'h0);
      run("t6", 16'h0240, 16'h0080);
      chk("t6_err", {31'd0, cap_err}, 32'd0);
      chk("t6_vx", {16'd0, cap_vx}, 32'h0);
      chk("t6_vy", {16'd0, cap_vy}, 32'h0080);

      // T7: reset in WAIT of seg2, start held across release
      clear_segs();
      seg(0, 2'd0, 1, 1, 16'h0, 16'h0);
      seg(1, 2'd0, 1, 0, 16'h0, 16'h0);
      s_nv[2] = 1;
      @(posedge clk); #1;
      arm(12'd7, 12'd9, 16'h0300, 16'h0400);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (o_busy && o_seg_idx == 4'd2 && !o_seg_req) found = 1;
      end
      chk("t7_reach_wait2", {31'd0, found}, 32'd1);
      #1;
      rst = 1'b1; i_start = 1'b1;
      exp_done = -1;
      h_vx = '0; h_vy = '0; h_col = 0; h_off = 0; h_err = 0;
      @(posedge clk); #1;
      chk("t7_rst_idx", {28'd0, o_seg_idx}, 32'd0);
      chk("t7_rst_x", {20'd0, o_x}, 32'd0);
      chk("t7_rst_cv", {16'd0, o_chk_v_x}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_segs();
      seg(0, 2'd0, 1, 0, 16'h0, 16'h0);
      seg(1, 2'd3, 0, 0, 16'h0, 16'h0);
      arm(12'd100, 12'd50, 16'h0180, 16'h0080);
      repeat (3) @(posedge clk);
      #1;
      i_start = 1'b0;
      wait_done("t7");
      chk("t7_lat", cap_cyc - t0, 32'd5);
      chk("t7_vx", {16'd0, cap_vx}, 32'h0180);
      repeat (8) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
